// File: rtl/axi_rd_arbiter.sv
// Shares one AXI read channel between the icache and dcache refill ports.
// One INCR burst is in flight at a time; the beats are assembled into a cache block.
module axi_rd_arbiter #(
    parameter int         BLK_BITS = 256,
    parameter logic [3:0] ID_IC    = 4'd0,
    parameter logic [3:0] ID_DC    = 4'd1
) (
    input  logic                aclk,
    input  logic                aresetn,
    input  logic                ic_ren,
    input  logic [31:0]         ic_raddr,
    output logic                ic_rrdy,
    output logic                ic_rvalid,
    output logic [BLK_BITS-1:0] ic_rdata,
    input  logic                dc_ren,
    input  logic [31:0]         dc_raddr,
    output logic                dc_rrdy,
    output logic                dc_rvalid,
    output logic [BLK_BITS-1:0] dc_rdata,
    output logic                rd_err,
    output logic [3:0]          arid,
    output logic [31:0]         araddr,
    output logic [7:0]          arlen,
    output logic [2:0]          arsize,
    output logic [1:0]          arburst,
    output logic                arvalid,
    input  logic                arready,
    input  logic [3:0]          rid,
    input  logic [31:0]         rdata,
    input  logic [1:0]          rresp,
    input  logic                rlast,
    input  logic                rvalid,
    output logic                rready
);

    localparam int BEATS = BLK_BITS / 32;
    localparam int CW    = $clog2(BEATS + 1);
    localparam logic [CW-1:0] BEATS_C = CW'(BEATS);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_AR   = 2'd1;
    localparam logic [1:0] S_R    = 2'd2;
    localparam logic [1:0] S_DONE = 2'd3;

    localparam logic PORT_IC = 1'b0;
    localparam logic PORT_DC = 1'b1;

    logic [1:0]          state;
    logic                owner;
    logic                last_grant;
    logic [CW-1:0]       beat_cnt;
    logic                err;
    logic [BLK_BITS-1:0] blk;
    logic                idle;
    logic                unused_rid;

    // Only one burst is ever outstanding, so the returned ID carries no information.
    assign unused_rid = ^rid;

    assign idle = (state == S_IDLE);

    // On a tie the port that did not win last time is granted.
    assign ic_rrdy = idle & ic_ren & (~dc_ren | (last_grant == PORT_DC));
    assign dc_rrdy = idle & dc_ren & (~ic_ren | (last_grant == PORT_IC));

    assign arlen   = 8'(BEATS - 1);
    assign arsize  = 3'b010;
    assign arburst = 2'b01;

    assign arvalid = (state == S_AR);
    assign rready  = (state == S_R);

    assign ic_rvalid = (state == S_DONE) & (owner == PORT_IC);
    assign dc_rvalid = (state == S_DONE) & (owner == PORT_DC);
    assign rd_err    = (state == S_DONE) & err;

    assign ic_rdata = blk;
    assign dc_rdata = blk;

    always_ff @(posedge aclk) begin
        if (!aresetn) begin
            state      <= S_IDLE;
            owner      <= PORT_IC;
            last_grant <= PORT_IC;
            beat_cnt   <= '0;
            err        <= 1'b0;
            blk        <= '0;
            araddr     <= '0;
            arid       <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (ic_rrdy) begin
                        araddr     <= ic_raddr;
                        arid       <= ID_IC;
                        owner      <= PORT_IC;
                        last_grant <= PORT_IC;
                        beat_cnt   <= '0;
                        err        <= 1'b0;
                        state      <= S_AR;
                    end else if (dc_rrdy) begin
                        araddr     <= dc_raddr;
                        arid       <= ID_DC;
                        owner      <= PORT_DC;
                        last_grant <= PORT_DC;
                        beat_cnt   <= '0;
                        err        <= 1'b0;
                        state      <= S_AR;
                    end
                end
                S_AR: begin
                    if (arready) begin
                        state <= S_R;
                    end
                end
                S_R: begin
                    // Surplus beats past a full block are drained without being stored.
                    if (rvalid) begin
                        if (beat_cnt < BEATS_C) begin
                            for (int i = 0; i < BEATS; i++) begin
                                if (beat_cnt == CW'(i)) begin
                                    blk[32*i +: 32] <= rdata;
                                end
                            end
                            beat_cnt <= beat_cnt + 1'b1;
                        end
                        if (rresp != 2'b00) begin
                            err <= 1'b1;
                        end
                        if (rlast) begin
                            state <= S_DONE;
                        end
                    end
                end
                S_DONE: begin
                    state <= S_IDLE;
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: doc/axi_rd_arbiter.md
Name: axi_rd_arbiter

Overview:
- Shares the single AXI read-address and read-data channel between the instruction-cache and data-cache refill ports.
- Accepts one block-refill request at a time and issues it as one INCR burst.
- Assembles the returned 32-bit beats into a cache block and returns the block to the requester that issued it.
- Sits between inst_cache/data_cache and the AXI master port, inside the mycpu_top level.

Parameters:
- BLK_BITS, 256: cache block width in bits; must be a multiple of 32. Beat count BEATS = BLK_BITS/32.
- ID_IC, 4'd0: arid used for instruction-cache bursts.
- ID_DC, 4'd1: arid used for data-cache bursts.

Ports:
- aclk  in  1  clock
- aresetn  in  1  synchronous active-low reset
- ic_ren  in  1  icache refill request
- ic_raddr  in  32  icache block address
- ic_rrdy  out  1  request accepted (combinational)
- ic_rvalid  out  1  one-cycle block-return pulse
- ic_rdata  out  BLK_BITS  returned block
- dc_ren  in  1  dcache refill request
- dc_raddr  in  32  dcache block address
- dc_rrdy  out  1  request accepted (combinational)
- dc_rvalid  out  1  one-cycle block-return pulse
- dc_rdata  out  BLK_BITS  returned block
- rd_err  out  1  pulses with rvalid if any beat had rresp!=0
- arid  out  4  burst ID
- araddr  out  32  burst address
- arlen  out  8  burst length field
- arsize  out  3  beat size
- arburst  out  2  burst type
- arvalid  out  1  read-address valid
- arready  in  1  read-address ready
- rid  in  4  read-data ID (ignored; one outstanding burst)
- rdata  in  32  read-data beat
- rresp  in  2  read-data response
- rlast  in  1  last beat of burst
- rvalid  in  1  read-data valid
- rready  out  1  read-data ready

Behaviour:
- Clocking and reset: one clock, aclk; reset is synchronous, active-low, aresetn. All state is updated on the rising edge of aclk.
- Reset (aresetn=0 sampled at a rising edge):
  - state=IDLE, beat_cnt=0, err=0, last_grant=IC.
  - arvalid, rready, ic_rvalid, dc_rvalid, rd_err = 0.
  - Block buffer, araddr, arid = 0.
  - Reset mid-burst abandons the burst; no rvalid pulse is issued for it.
- Constant outputs: arlen=BEATS-1 (8'd7 at default), arsize=3'b010, arburst=2'b01 (INCR).
- Requester handshake:
  - The requester holds ren and raddr stable until it sees rrdy=1 in the same cycle as ren; that cycle is the accept.
  - rrdy is high only in IDLE, and only to the arbitration winner.
- Arbitration (IDLE):
  - Only one ren high: that port wins.
  - Both high: the port not equal to last_grant wins (round-robin). After reset the first tie goes to DC.
  - On accept: latch araddr=raddr, arid=ID of winner, owner=winner, last_grant=winner; clear beat_cnt and err; go to AR.
- AR:
  - arvalid=1; araddr and arid are held stable.
  - On arready=1: arvalid drops next cycle; go to R.
- R:
  - rready=1.
  - Each rvalid&rready beat writes rdata to block bits [32*beat_cnt+31 : 32*beat_cnt], then beat_cnt increments.
  - Beats beyond BEATS are consumed but not written; beat_cnt saturates at BEATS.
  - rresp!=2'b00 on any beat sets err.
  - A beat with rlast=1 ends the burst; go to DONE.
- DONE (exactly one cycle):
  - owner's rvalid=1, rd_err=err; go to IDLE.
  - A new request may be accepted in the cycle after DONE.
  - A short burst (rlast before BEATS beats) still completes; unwritten slices keep stale data.
- ic_rdata and dc_rdata both drive the shared block buffer.
  - The value is valid during the owner's rvalid pulse and is held until the next burst writes its first beat.
  - The non-owner's rvalid stays 0.
- Latency:
  - Accept cycle, then AR for at least 1 cycle, then R for N beats, then DONE.
  - With arready=1 and a back-to-back rvalid stream, the rvalid pulse arrives BEATS+2 cycles after accept.
- A request that arrives during a burst waits (rrdy=0) and is never dropped.
- ren is ignored outside IDLE.

Test Plan:
- ic_ren=1, ic_raddr=0x1C000000, arready=1, 8 beats rdata=0..7, rlast on beat 8:
  - arid=0, araddr=0x1C000000, arlen=7, arsize=2, arburst=1.
  - ic_rvalid pulses one cycle with block word[i]=i; dc_rvalid=0; rd_err=0.
- ic_ren and dc_ren both high from reset:
  - DC is accepted first (arid=1).
  - After its DONE, IC is accepted (arid=0).
  - Repeat the tie: DC wins the third accept.
- arready held 0 for 5 cycles during AR:
  - arvalid stays 1 with araddr stable.
  - rready stays 0 until AR completes.
- Beat 3 of 8 has rresp=2'b10: dc_rvalid pulses with rd_err=1 and all 8 words written.
- rvalid gaps of 0–3 cycles between beats, or rlast asserted on beat 5:
  - Gaps: the block still assembles correctly.
  - Early rlast: completion one cycle later; words 5–7 retain their previous values.
- aresetn=0 for one cycle during beat 4:
  - All outputs return to 0; no rvalid pulse.
  - A subsequent request is accepted normally.
